memory_arbiter: RTL
===================

// Module: memory_arbiter
// PURPOSE
//  Memory-side responder for the cache request protocol: accepts word requests from icache
//  (iREN/iaddr) and dcache (dREN/dWEN/daddr/dstore) and drives a single-ported RAM.
//  Registered arbitration FSM: dcache has priority; a starvation counter bounds icache delay.
//  Returns iwait/dwait and load data to the granted cache. Sits between the caches and RAM.
// PARAMETERS
//  ADDR_W      32  byte-address width of iaddr/daddr/ramaddr
//  DATA_W      32  word width of load/store data
//  STARVE_MAX  4   consecutive dcache grants with iREN pending before icache is forced (>=1)
// PORTS
//  CLK       in   1       clock, rising edge
//  nRST      in   1       reset, asynchronous, active-low
//  iREN      in   1       icache read request
//  iaddr     in   ADDR_W  icache address
//  iwait     out  1       0 = icache word complete this cycle
//  iload     out  DATA_W  icache read data
//  dREN      in   1       dcache read request
//  dWEN      in   1       dcache write request (wins if both dREN and dWEN)
//  daddr     in   ADDR_W  dcache address
//  dstore    in   DATA_W  dcache write data
//  dwait     out  1       0 = dcache word complete this cycle
//  dload     out  DATA_W  dcache read data
//  ramREN    out  1       RAM read enable
//  ramWEN    out  1       RAM write enable
//  ramaddr   out  ADDR_W  RAM address
//  ramstore  out  DATA_W  RAM write data
//  ramload   in   DATA_W  RAM read data
//  ramstate  in   2       ramstate_t: FREE, BUSY, ACCESS, ERROR
//  ram_err   out  1       sticky: an ERROR response was seen
// BEHAVIOUR
//  - Reset: state IDLE, starve_cnt 0, ram_err 0; iwait=1, dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0.
//  - States: IDLE, GRANT_D, GRANT_I (registered). RAM enables only driven in GRANT_*; never both.
//  - IDLE: dreq=dREN|dWEN. If dreq && !(iREN && starve_cnt==STARVE_MAX) -> GRANT_D;
//    else if iREN -> GRANT_I; else stay. Grant decision costs 1 cycle (min latency 2 cycles).
//  - GRANT_D: ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore (live, combinational).
//    ramstate==ACCESS: dwait=0 same cycle, next IDLE. GRANT_I identical with iREN/iaddr, ramWEN=0.
//  - iload=dload=ramload, combinational pass-through always; valid only when the matching wait is 0.
//  - Request dropped while granted (dREN=dWEN=0 in GRANT_D, or iREN=0 in GRANT_I): RAM enables 0,
//    wait stays 1, next IDLE. Address change mid-grant is forwarded unchanged (cache holds stable).
//  - ramstate ERROR in GRANT_*: wait stays 1, ram_err<=1 (sticky until reset), next IDLE; request re-arbitrated.
//  - FREE/BUSY in GRANT_*: hold state, wait=1.
//  - starve_cnt (width clog2(STARVE_MAX+1)): on GRANT_D completion with iREN=1 -> +1, saturating at
//    STARVE_MAX; on GRANT_I completion -> 0; dcache completion with iREN=0 -> 0.
//  - Async reset mid-grant: immediate return to reset values; no partial completion signalled.
// STRUCTURE
//  - cpu_types_pkg: ramstate_t (existing), word_t; add arb_state_t {IDLE, GRANT_D, GRANT_I}.
//  - Single module; starvation counter inline (saturating, clear-on-I-grant); no sub-module needed.
//  - Separate always_ff for state/starve_cnt/ram_err and always_comb for next-state and outputs.
// TESTING
//  1 dREN=1,daddr=0x100; RAM ACCESS after 2 BUSY, ramload=0xDEADBEEF -> dwait=0 exactly 1 cycle, dload=0xDEADBEEF, back to IDLE.
//  2 dWEN=1,daddr=0x200,dstore=0x12345678 -> ramWEN=1,ramaddr=0x200,ramstore=0x12345678; ramREN=0 throughout.
//  3 iREN and dREN held 1 (auto re-request), STARVE_MAX=4 -> grant order D,D,D,D,I,D...; iwait=0 on 5th completion.
//  4 GRANT_D, dREN drops before ACCESS -> ramREN=0 same cycle, dwait stays 1, IDLE next cycle, then GRANT_I if iREN.
//  5 ramstate=ERROR during GRANT_I -> iwait stays 1, ram_err=1 and remains 1; next request served normally.
//  6 nRST asserted mid GRANT_D -> iwait=dwait=1, ram enables 0 immediately; starve_cnt=0, ram_err=0 after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory request protocol.
package cpu_types_pkg;

  // Response state reported by the RAM model on every cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Native machine word.
  typedef logic [31:0] word_t;

  // Memory arbiter FSM states; the grant is registered, so a request
  // always spends one cycle in IDLE before reaching the RAM.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Memory-side responder for the icache/dcache request protocol.
// A registered FSM grants the single-ported RAM to one cache at a time.
// dcache normally wins; a saturating starvation counter forces an icache
// grant once STARVE_MAX dcache words completed while iREN was waiting.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ram_err
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;
  logic             set_err;
  logic             dreq;
  logic             force_i;
  ramstate_t        rs;

  // Saturating increment of the starvation counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  assign rs      = ramstate_t'(ramstate);
  assign dreq    = dREN | dWEN;
  assign force_i = iREN && (starve_cnt == CNT_MAX);

  // Load data is a plain pass-through; each cache qualifies it with its wait.
  assign iload = ramload;
  assign dload = ramload;

  // Registered control: FSM state, starvation counter and sticky error flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ram_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (set_err) ram_err <= 1'b1;
    end
  end

  // Next-state decode and RAM/cache handshake outputs.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    set_err    = 1'b0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;

    case (state)
      IDLE: begin
        if (dreq && !force_i) begin
          state_nxt = GRANT_D;
        end else if (iREN) begin
          state_nxt = GRANT_I;
        end
      end

      GRANT_D: begin
        if (!dreq) begin
          // Request withdrawn: release the RAM without completing.
          state_nxt = IDLE;
        end else begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          case (rs)
            ACCESS: begin
              dwait      = 1'b0;
              state_nxt  = IDLE;
              starve_nxt = iREN ? sat_inc(starve_cnt) : '0;
            end
            ERROR: begin
              set_err   = 1'b1;
              state_nxt = IDLE;
            end
            default: ;
          endcase
        end
      end

      GRANT_I: begin
        if (!iREN) begin
          state_nxt = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          case (rs)
            ACCESS: begin
              iwait      = 1'b0;
              state_nxt  = IDLE;
              starve_nxt = '0;
            end
            ERROR: begin
              set_err   = 1'b1;
              state_nxt = IDLE;
            end
            default: ;
          endcase
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
